// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting right after the PC register.
//
// Each cycle it may issue a read of the synchronous instruction memory at
// pc_in (1-cycle read latency). The word that comes back is paired with its
// PC and pushed into a small circular fetch queue. Decode takes entries from
// that queue over a valid/ready handshake. The block only requests a fetch
// when the queue is certain to have room for the result, and that same
// condition drives the PC advance enable. A redirect (flush_in) empties the
// queue and drops any response that is still on its way.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   When defined, each entry carries a misaligned flag (pc[1:0] != 0) that
//   is captured at issue. A flagged entry is still enqueued, but with its
//   instruction word forced to zero. The trap itself is taken downstream.
//
// Ports:
//   clk                 clock; all state updates on posedge
//   rst                 synchronous active-high reset
//   pc_in               current PC from the PC register
//   pc_advance_out      PC step enable (+4 at the end of this cycle)
//   flush_in            redirect this cycle (PC loads its target at the edge)
//   imem_en_out         instruction-memory read enable
//   imem_addr_out       instruction-memory byte address (always pc_in)
//   imem_rdata_in       read data, valid the cycle after imem_en_out
//   inst_out            head instruction
//   inst_pc_out         PC of the head instruction
//   inst_valid_out      head valid
//   inst_ready_in       decode accepts the head
//   inst_misaligned_out head misaligned flag (only with FETCH_MISALIGN_TRAP_EN)

module fetch_unit #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_in,
    output logic              pc_advance_out,
    input  logic              flush_in,
    output logic              imem_en_out,
    output logic [AWIDTH-1:0] imem_addr_out,
    input  logic [DWIDTH-1:0] imem_rdata_in,
    output logic [DWIDTH-1:0] inst_out,
    output logic [AWIDTH-1:0] inst_pc_out,
    output logic              inst_valid_out,
    input  logic              inst_ready_in
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              inst_misaligned_out
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              inflight_reg;
    logic [AWIDTH-1:0] req_pc_reg;

    logic [DWIDTH-1:0] data_mem [DEPTH];
    logic [AWIDTH-1:0] pc_mem   [DEPTH];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic              req_mis_reg;
    logic              mis_mem [DEPTH];
`endif

    logic              head_valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [DWIDTH-1:0] push_data;

    // Head visibility is gated by rst so that the outputs go quiet in the
    // very first reset cycle, before the registers have been cleared.
    assign head_valid = (count_reg != '0) && !rst;
    assign pop        = head_valid && inst_ready_in && !flush_in;
    assign push       = inflight_reg && !flush_in && !rst;

    // A request is only made when the queue will have a slot for it by the
    // time the data returns: entries held plus the one in flight, minus the
    // one decode is taking this cycle, must leave room.
    assign issue = !rst && !flush_in &&
                   ((int'(count_reg) + int'(inflight_reg)) < (DEPTH + int'(pop)));

    assign imem_en_out    = issue;
    assign pc_advance_out = issue;
    assign imem_addr_out  = pc_in;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign push_data = req_mis_reg ? '0 : imem_rdata_in;
`else
    assign push_data = imem_rdata_in;
`endif

    // Outputs read zero whenever no head is presented. While the head is
    // valid and not accepted, the head pointer and the stored entry do not
    // change, so the values are held.
    assign inst_valid_out = head_valid;
    assign inst_out       = head_valid ? data_mem[rd_ptr_reg] : '0;
    assign inst_pc_out    = head_valid ? pc_mem[rd_ptr_reg]   : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign inst_misaligned_out = head_valid ? mis_mem[rd_ptr_reg] : 1'b0;
`endif

    // Control state: pointers, occupancy and the single outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= 1'b0;
            req_pc_reg   <= '0;
        end else if (flush_in) begin
            // Redirect: everything queued or in flight belongs to the old
            // stream and is dropped.
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                req_pc_reg <= pc_in;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Queue storage. No reset is needed: an entry is only read after it
    // has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= push_data;
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            req_mis_reg <= 1'b0;
        end else if (issue) begin
            req_mis_reg <= (pc_in[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mis_mem[wr_ptr_reg] <= req_mis_reg;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (AWIDTH=DWIDTH=32,
// DEPTH=2). It models the PC register and a 1-cycle synchronous memory
// returning addr ^ 0xA5A5_A5A5. A scoreboard records each issued request
// with its expected word and matches it against every accepted head.
// Scenario tasks add targeted checks.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] XOR_PAT  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic        pc_advance_out;
    logic        flush_in = 1'b0;
    logic        imem_en_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in = '0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_valid_out;
    logic        inst_ready_in = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        inst_misaligned_out;
`endif

    logic [31:0] pc_reg = RESET_PC;
    logic [31:0] flush_target = '0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t ne;

    fetch_unit #(.AWIDTH(32), .DWIDTH(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_advance_out (pc_advance_out),
        .flush_in       (flush_in),
        .imem_en_out    (imem_en_out),
        .imem_addr_out  (imem_addr_out),
        .imem_rdata_in  (imem_rdata_in),
        .inst_out       (inst_out),
        .inst_pc_out    (inst_pc_out),
        .inst_valid_out (inst_valid_out),
        .inst_ready_in  (inst_ready_in)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .inst_misaligned_out (inst_misaligned_out)
`endif
    );

    always #5 clk = ~clk;

    // PC register model: reset, redirect load, or +4 step.
    always @(posedge clk) begin
        if (rst)                 pc_reg <= RESET_PC;
        else if (flush_in)       pc_reg <= flush_target;
        else if (pc_advance_out) pc_reg <= pc_reg + 32'd4;
    end
    assign pc_in = pc_reg;

    // Synchronous memory: garbage when not enabled, so a stray push is visible.
    always @(posedge clk) begin
        if (imem_en_out) imem_rdata_in <= imem_addr_out ^ XOR_PAT;
        else             imem_rdata_in <= $urandom;
    end

    // Scoreboard: push expected word on issue, compare on accepted head.
    always @(negedge clk) begin
        if (rst || flush_in) begin
            sb.delete();
        end else begin
            if (inst_valid_out && inst_ready_in) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got pc=%h data=%h, required no entry",
                             inst_pc_out, inst_out);
                end else begin
                    e = sb.pop_front();
                    if (inst_pc_out !== e.pc || inst_out !== e.data
`ifdef FETCH_MISALIGN_TRAP_EN
                        || inst_misaligned_out !== e.mis
`endif
                        ) begin
                        $display("FAIL sb_pop: got pc=%h data=%h, required pc=%h data=%h",
                                 inst_pc_out, inst_out, e.pc, e.data);
                    end else begin
                        n_pass++;
                        $display("pop pc=%h data=%h", inst_pc_out, inst_out);
                    end
                end
            end
            if (imem_en_out) begin
                ne.pc  = pc_in;
                ne.mis = (pc_in[1:0] != 2'b00);
`ifdef FETCH_MISALIGN_TRAP_EN
                ne.data = ne.mis ? 32'h0 : (pc_in ^ XOR_PAT);
`else
                ne.data = pc_in ^ XOR_PAT;
`endif
                sb.push_back(ne);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if ({inst_valid_out, imem_en_out, pc_advance_out} !== 3'b000 ||
                inst_out !== 32'h0 || inst_pc_out !== 32'h0) begin
                $display("FAIL reset_quiet: got v/en/adv=%b%b%b inst=%h pc=%h, required 000 0 0",
                         inst_valid_out, imem_en_out, pc_advance_out, inst_out, inst_pc_out);
            end else n_pass++;
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (imem_en_out !== 1'b1 || imem_addr_out !== RESET_PC) begin
            $display("FAIL first_issue: got en=%b addr=%h, required en=1 addr=%h",
                     imem_en_out, imem_addr_out, RESET_PC);
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b0) begin
            $display("FAIL latency_t1: got valid=%b, required 0", inst_valid_out);
        end else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (inst_valid_out !== 1'b1 || inst_pc_out !== RESET_PC + 32'(4 * k)) begin
                $display("FAIL stream_%0d: got valid=%b pc=%h, required valid=1 pc=%h",
                         k, inst_valid_out, inst_pc_out, RESET_PC + 32'(4 * k));
            end else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold;
        hold = '0;
        tick();
        inst_ready_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0 && sb.size() != 0) hold = sb[0].pc;
            n_total++;
            if (inst_valid_out !== 1'b1 || inst_pc_out !== hold ||
                inst_out !== (hold ^ XOR_PAT) || pc_advance_out !== 1'b0) begin
                $display("FAIL bp_hold_%0d: got valid=%b pc=%h inst=%h adv=%b, required 1 %h %h 0",
                         k, inst_valid_out, inst_pc_out, inst_out, pc_advance_out,
                         hold, hold ^ XOR_PAT);
            end else n_pass++;
        end
        tick();
        inst_ready_in = 1'b1;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b1 || inst_pc_out !== hold) begin
            $display("FAIL bp_release: got valid=%b pc=%h, required 1 %h",
                     inst_valid_out, inst_pc_out, hold);
        end else n_pass++;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_flush();
        tick();
        flush_in = 1'b1;
        flush_target = 32'h2000_0000;
        @(negedge clk);
        n_total++;
        if (imem_en_out !== 1'b0 || pc_advance_out !== 1'b0) begin
            $display("FAIL flush_noissue: got en=%b adv=%b, required 0 0",
                     imem_en_out, pc_advance_out);
        end else n_pass++;
        tick();
        flush_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b0 || imem_en_out !== 1'b1 || imem_addr_out !== 32'h2000_0000) begin
            $display("FAIL flush_next: got valid=%b en=%b addr=%h, required 0 1 20000000",
                     inst_valid_out, imem_en_out, imem_addr_out);
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b0) begin
            $display("FAIL flush_stale: got valid=%b pc=%h, required valid=0",
                     inst_valid_out, inst_pc_out);
        end else n_pass++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_total++;
            if (inst_valid_out !== 1'b1 || inst_pc_out !== 32'h2000_0000 + 32'(4 * k)) begin
                $display("FAIL flush_stream_%0d: got valid=%b pc=%h, required 1 %h",
                         k, inst_valid_out, inst_pc_out, 32'h2000_0000 + 32'(4 * k));
            end else n_pass++;
        end
    endtask

    task automatic test_flush_full();
        bit found;
        tick();
        inst_ready_in = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b1 || pc_advance_out !== 1'b0) begin
            $display("FAIL full_state: got valid=%b adv=%b, required 1 0",
                     inst_valid_out, pc_advance_out);
        end else n_pass++;
        tick();
        flush_in = 1'b1;
        inst_ready_in = 1'b1;
        flush_target = 32'h2000_0000;
        tick();
        flush_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b0) begin
            $display("FAIL full_flush_empty: got valid=%b pc=%h, required valid=0",
                     inst_valid_out, inst_pc_out);
        end else n_pass++;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (inst_valid_out) found = 1;
        end
        n_total++;
        if (!found || inst_pc_out !== 32'h2000_0000) begin
            $display("FAIL full_flush_first: got found=%0d pc=%h, required 1 20000000",
                     found, inst_pc_out);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit found;
        tick();
        flush_in = 1'b1;
        flush_target = 32'h3000_0000;
        tick();
        flush_target = 32'h3000_0100;
        tick();
        flush_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b0 || imem_addr_out !== 32'h3000_0100) begin
            $display("FAIL b2b_restart: got valid=%b addr=%h, required 0 30000100",
                     inst_valid_out, imem_addr_out);
        end else n_pass++;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (inst_valid_out) found = 1;
        end
        n_total++;
        if (!found || inst_pc_out !== 32'h3000_0100) begin
            $display("FAIL b2b_first: got found=%0d pc=%h, required 1 30000100",
                     found, inst_pc_out);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        tick();
        inst_ready_in = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({inst_valid_out, imem_en_out, pc_advance_out} !== 3'b000 ||
            inst_out !== 32'h0 || inst_pc_out !== 32'h0) begin
            $display("FAIL midrst_during: got v/en/adv=%b%b%b inst=%h pc=%h, required 000 0 0",
                     inst_valid_out, imem_en_out, pc_advance_out, inst_out, inst_pc_out);
        end else n_pass++;
        tick();
        rst = 1'b0;
        inst_ready_in = 1'b1;
        @(negedge clk);
        n_total++;
        if (inst_valid_out !== 1'b0 || inst_out !== 32'h0 || inst_pc_out !== 32'h0 ||
            imem_en_out !== 1'b1 || imem_addr_out !== RESET_PC) begin
            $display("FAIL midrst_after: got v=%b inst=%h pc=%h en=%b addr=%h, required 0 0 0 1 %h",
                     inst_valid_out, inst_out, inst_pc_out, imem_en_out, imem_addr_out, RESET_PC);
        end else n_pass++;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (inst_valid_out) found = 1;
        end
        n_total++;
        if (!found || inst_pc_out !== RESET_PC) begin
            $display("FAIL midrst_first: got found=%0d pc=%h, required 1 %h",
                     found, inst_pc_out, RESET_PC);
        end else n_pass++;
    endtask

    task automatic test_misalign();
        bit found;
        logic [31:0] want;
`ifdef FETCH_MISALIGN_TRAP_EN
        want = 32'h0;
`else
        want = 32'h4000_0002 ^ XOR_PAT;
`endif
        tick();
        flush_in = 1'b1;
        flush_target = 32'h4000_0002;
        tick();
        flush_in = 1'b0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (inst_valid_out) found = 1;
        end
        n_total++;
        if (!found || inst_pc_out !== 32'h4000_0002 || inst_out !== want
`ifdef FETCH_MISALIGN_TRAP_EN
            || inst_misaligned_out !== 1'b1
`endif
            ) begin
            $display("FAIL misalign: got found=%0d pc=%h inst=%h, required 1 40000002 %h",
                     found, inst_pc_out, inst_out, want);
        end else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            tick();
            inst_ready_in = 1'($urandom_range(0, 1));
            flush_in = ($urandom_range(0, 19) == 0);
            flush_target = {4'h1, 16'($urandom), 10'($urandom), 2'b00};
        end
        tick();
        flush_in = 1'b0;
        inst_ready_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_flush();
        test_flush_full();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
